// File: rtl/dac_stream_seq.sv
// Sample sequencer: buffers tagged DAC codes from the core and releases one per
// rate tick to the addressed channel register, holding the last code on underrun.
module dac_stream_seq #(
    parameter int DW = 10,
    parameter int NCH = 2,
    parameter int DEPTH = 8,
    parameter int DIVW = 16,
    parameter logic [DW-1:0] RST_CODE = '0,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIVW-1:0]   rate_div,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic [CW-1:0]     s_chan,
    output logic [NCH*DW-1:0] dac_d,
    output logic [NCH-1:0]    dac_upd,
    output logic [AW:0]       level,
    output logic [7:0]        underrun_cnt,
    input  logic              clr_underrun
);

    logic [CW+DW-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DIVW-1:0]  div_cnt;
    logic             full;
    logic             empty;
    logic             tick;
    logic             push;
    logic             write;
    logic             pop;
    logic             underrun;
    logic [CW-1:0]    head_chan;
    logic [DW-1:0]    head_data;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    assign s_ready = reset && !full && !flush;
    assign push    = s_valid && s_ready;
    // Beats addressed to a nonexistent channel are swallowed without a FIFO write.
    assign write   = push && (32'(s_chan) < NCH);

    assign tick     = enable && (div_cnt >= rate_div);
    assign pop      = tick && !empty && !flush;
    assign underrun = tick && empty && !flush;

    assign {head_chan, head_data} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (write)
            mem[wr_ptr[AW-1:0]] <= {s_chan, s_data};
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            div_cnt      <= '0;
            underrun_cnt <= '0;
        end else begin
            if (write)
                wr_ptr <= wr_ptr + 1'b1;
            if (flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (!enable)
                div_cnt <= '0;
            else if (tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            // Clear takes priority over a coincident underrun.
            if (clr_underrun)
                underrun_cnt <= '0;
            else if (underrun && underrun_cnt != 8'hFF)
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++)
                dac_d[c*DW +: DW] <= RST_CODE;
            dac_upd <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                dac_upd[c] <= pop && (head_chan == CW'(c));
                if (pop && (head_chan == CW'(c)))
                    dac_d[c*DW +: DW] <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_dac_stream_seq.sv
// Directed bench for dac_stream_seq with three channels so that an out-of-range
// channel index exists; all expected values are hand-computed.
module tb_dac_stream_seq;

    localparam int DW = 10;
    localparam int NCH = 3;
    localparam int DEPTH = 8;
    localparam int DIVW = 16;
    localparam int CW = 2;
    localparam int AW = 3;
    localparam logic [DW-1:0] RCODE = 10'h200;

    logic              CLK = 1'b0;
    logic              reset;
    logic              enable;
    logic [DIVW-1:0]   rate_div;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [CW-1:0]     s_chan;
    logic [NCH*DW-1:0] dac_d;
    logic [NCH-1:0]    dac_upd;
    logic [AW:0]       level;
    logic [7:0]        underrun_cnt;
    logic              clr_underrun;

    int tests = 0;
    int fails = 0;

    dac_stream_seq #(
        .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .DIVW(DIVW), .RST_CODE(RCODE)
    ) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .rate_div(rate_div),
        .flush(flush), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_chan(s_chan), .dac_d(dac_d), .dac_upd(dac_upd), .level(level),
        .underrun_cnt(underrun_cnt), .clr_underrun(clr_underrun)
    );

    always #5 CLK = ~CLK;

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [CW-1:0] chan, input logic [DW-1:0] data);
        s_valid = 1'b1;
        s_chan  = chan;
        s_data  = data;
        cycle(1);
        s_valid = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] slice(input int c);
        return dac_d[c*DW +: DW];
    endfunction

    initial begin
        reset = 1'b0; enable = 1'b0; rate_div = '0; flush = 1'b0;
        s_valid = 1'b0; s_data = '0; s_chan = '0; clr_underrun = 1'b0;
        cycle(3);
        check_output("ready_in_reset", 64'(s_ready), 64'd0);
        check_output("dac_in_reset", 64'(dac_d), 64'({RCODE, RCODE, RCODE}));

        reset = 1'b1;
        #1;
        check_output("ready_after_release", 64'(s_ready), 64'd1);
        check_output("level_after_release", 64'(level), 64'd0);
        check_output("upd_after_release", 64'(dac_upd), 64'd0);
        check_output("underrun_after_release", 64'(underrun_cnt), 64'd0);

        // Basic streaming at rate_div=3
        apply_stimulus(2'd0, 10'h155);
        apply_stimulus(2'd1, 10'h2AA);
        check_output("level_two_queued", 64'(level), 64'd2);
        enable = 1'b1; rate_div = 16'd3;
        cycle(3);
        check_output("no_early_tick", 64'(dac_upd), 64'd0);
        check_output("ch0_before_tick", 64'(slice(0)), 64'h200);
        cycle(1);
        check_output("ch0_first_pop", 64'(slice(0)), 64'h155);
        check_output("upd_first_pop", 64'(dac_upd), 64'b001);
        check_output("level_after_pop1", 64'(level), 64'd1);
        cycle(3);
        check_output("upd_pulse_ends", 64'(dac_upd), 64'd0);
        check_output("ch1_before_tick", 64'(slice(1)), 64'h200);
        cycle(1);
        check_output("ch1_second_pop", 64'(slice(1)), 64'h2AA);
        check_output("upd_second_pop", 64'(dac_upd), 64'b010);
        check_output("level_after_pop2", 64'(level), 64'd0);
        enable = 1'b0;
        cycle(1);
        check_output("no_underrun_yet", 64'(underrun_cnt), 64'd0);

        // Fill to full with the divider stopped, then drain at one sample per cycle
        for (int i = 0; i < 8; i++)
            apply_stimulus(CW'(i % 3), DW'(10'h100 + i));
        check_output("level_full", 64'(level), 64'd8);
        check_output("ready_full", 64'(s_ready), 64'd0);
        s_valid = 1'b1; s_chan = 2'd2; s_data = 10'h108;
        cycle(2);
        check_output("ninth_held_level", 64'(level), 64'd8);
        check_output("ninth_held_ready", 64'(s_ready), 64'd0);
        enable = 1'b1; rate_div = 16'd0;
        cycle(1);
        check_output("level_after_first_drain", 64'(level), 64'd7);
        check_output("ready_after_first_drain", 64'(s_ready), 64'd1);
        check_output("drain_ch0", 64'(slice(0)), 64'h100);
        check_output("drain_upd0", 64'(dac_upd), 64'b001);
        cycle(1);
        s_valid = 1'b0;
        check_output("level_push_and_pop", 64'(level), 64'd7);
        check_output("drain_ch1", 64'(slice(1)), 64'h101);
        for (int k = 2; k <= 8; k++) begin
            cycle(1);
            check_output("drain_order_data", 64'(slice(k % 3)), 64'(10'h100 + k));
            check_output("drain_order_upd", 64'(dac_upd), 64'(1 << (k % 3)));
        end
        enable = 1'b0;
        check_output("level_drained", 64'(level), 64'd0);
        cycle(1);
        check_output("no_underrun_after_drain", 64'(underrun_cnt), 64'd0);

        // Underrun counting and saturation at rate_div=1
        enable = 1'b1; rate_div = 16'd1;
        cycle(20);
        check_output("underrun_10", 64'(underrun_cnt), 64'd10);
        cycle(580);
        check_output("underrun_saturated", 64'(underrun_cnt), 64'd255);
        check_output("dac_held_underrun", 64'(dac_d), 64'({10'h108, 10'h107, 10'h106}));
        check_output("upd_zero_underrun", 64'(dac_upd), 64'd0);
        cycle(1);
        check_output("underrun_still_sat", 64'(underrun_cnt), 64'd255);
        clr_underrun = 1'b1;
        cycle(1);
        clr_underrun = 1'b0;
        check_output("clear_wins", 64'(underrun_cnt), 64'd0);
        cycle(2);
        check_output("underrun_after_clear", 64'(underrun_cnt), 64'd1);
        enable = 1'b0;

        // Flush, with a coincident tick that must not pop
        for (int i = 0; i < 5; i++)
            apply_stimulus(2'd0, DW'(10'h3F0 + i));
        check_output("level_five", 64'(level), 64'd5);
        flush = 1'b1; enable = 1'b1; rate_div = 16'd0;
        #1;
        check_output("ready_during_flush", 64'(s_ready), 64'd0);
        cycle(1);
        flush = 1'b0; enable = 1'b0;
        check_output("level_flushed", 64'(level), 64'd0);
        check_output("upd_flush", 64'(dac_upd), 64'd0);
        check_output("ch0_flush_held", 64'(slice(0)), 64'h106);
        check_output("underrun_flush", 64'(underrun_cnt), 64'd1);
        flush = 1'b1; enable = 1'b1;
        cycle(1);
        flush = 1'b0; enable = 1'b0;
        check_output("underrun_empty_flush", 64'(underrun_cnt), 64'd1);

        // Out-of-range channel is consumed but not stored
        s_valid = 1'b1; s_chan = 2'd3; s_data = 10'h123;
        #1;
        check_output("ready_bad_chan", 64'(s_ready), 64'd1);
        cycle(1);
        s_valid = 1'b0;
        check_output("level_bad_chan", 64'(level), 64'd0);

        // Lowering rate_div below the running count ticks immediately
        apply_stimulus(2'd1, 10'h011);
        apply_stimulus(2'd1, 10'h022);
        apply_stimulus(2'd1, 10'h033);
        enable = 1'b1; rate_div = 16'd100;
        cycle(50);
        check_output("no_tick_at_50", 64'(dac_upd), 64'd0);
        check_output("level_three", 64'(level), 64'd3);
        rate_div = 16'd10;
        cycle(1);
        check_output("immediate_tick_data", 64'(slice(1)), 64'h011);
        check_output("immediate_tick_upd", 64'(dac_upd), 64'b010);
        cycle(10);
        check_output("no_tick_before_11", 64'(dac_upd), 64'd0);
        check_output("ch1_held_before_11", 64'(slice(1)), 64'h011);
        cycle(1);
        check_output("tick_after_11", 64'(slice(1)), 64'h022);
        check_output("level_one_left", 64'(level), 64'd1);

        // Asynchronous reset mid-stream
        reset = 1'b0;
        #1;
        check_output("async_reset_dac", 64'(dac_d), 64'({RCODE, RCODE, RCODE}));
        check_output("async_reset_level", 64'(level), 64'd0);
        check_output("async_reset_upd", 64'(dac_upd), 64'd0);
        check_output("async_reset_ready", 64'(s_ready), 64'd0);
        reset = 1'b1; enable = 1'b0;
        cycle(2);
        check_output("post_reset_level", 64'(level), 64'd0);
        check_output("post_reset_underrun", 64'(underrun_cnt), 64'd0);
        check_output("post_reset_dac", 64'(dac_d), 64'({RCODE, RCODE, RCODE}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
